// File: rtl/spi_reg_hub_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_hub_if
// Purpose  : SPI pin bundle plus sequential memory read port for spi_reg_hub.
// Revision : 1.0
// ============================================================================
interface spi_reg_hub_if #(
    parameter int MEM_W  = 16,
    parameter int MEM_AW = 11
);
    logic              ncs_spi;
    logic              sck_spi;
    logic              mosi_spi;
    logic              miso_spi;
    logic [MEM_AW-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_data;

    modport slave (
        input  ncs_spi, sck_spi, mosi_spi, mem_data,
        output miso_spi, mem_addr
    );

    modport master (
        output ncs_spi, sck_spi, mosi_spi, mem_data,
        input  miso_spi, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_hub.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_hub
// Purpose  : SPI mode-0 slave with NCH config registers and a status+memory
//            read stream. Define SPI_BURST_EN for multi-channel CFG bursts.
// Revision : 1.0
// ============================================================================
module spi_reg_hub #(
    parameter int                   NCH      = 4,
    parameter int                   CFG_W    = 32,
    parameter int                   STATUS_W = 16,
    parameter int                   MEM_W    = 16,
    parameter int                   MEM_AW   = 11,
    parameter logic [7:0]           DEV_ID   = 8'h91,
    parameter logic [NCH*CFG_W-1:0] CFG_RST  = '0
) (
    input  wire                   clk,
    input  wire                   nrst,
    spi_reg_hub_if.slave          bus,
    output logic [NCH*CFG_W-1:0]  cfg_out,
    output logic [NCH-1:0]        cfg_update,
    input  wire  [STATUS_W-1:0]   status_in,
    output logic                  spi_err,
    output logic                  spi_busy
);
    localparam int SH_W0 = (CFG_W > 8) ? CFG_W : 8;
    localparam int SH_W1 = (STATUS_W > SH_W0) ? STATUS_W : SH_W0;
    localparam int SH_W  = (MEM_W > SH_W1) ? MEM_W : SH_W1;
    localparam int RX_W  = SH_W0 - 1;
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam int CH_IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] CFG_LAST  = CNT_W'(CFG_W - 1);
    localparam logic [CNT_W-1:0] STAT_LAST = CNT_W'(STATUS_W - 1);
    localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CTRL = 3'd1,
        S_CFG  = 3'd2,
        S_STAT = 3'd3,
        S_MEM  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                     state_q;
    logic [2:0]                 sck_q;
    logic [2:0]                 ncs_q;
    logic [1:0]                 mosi_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [CH_IW-1:0]           ch_q;
    logic                       wr_q;
    logic [RX_W-1:0]            rx_q;
    logic [SH_W-1:0]            tx_q;
    logic                       miso_q;
    logic [NCH-1:0][CFG_W-1:0]  cfg_q;
    logic [NCH-1:0]             upd_q;
    logic [MEM_AW-1:0]          mem_addr_q;
    logic                       err_q;
    logic                       busy_q;

    logic                       sck_rise;
    logic                       sck_fall;
    logic                       ncs_fall;
    logic [SH_W0-1:0]           rx_word;
    logic [7:0]                 ctrl;
    logic                       ch_ok;
    logic [CH_IW-1:0]           ch_sel;

    // Index [1] is the synchronised level, [2] the one-clk-older copy.
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ncs_fall = ~ncs_q[1] & ncs_q[2];
    assign rx_word  = {rx_q, mosi_q[1]};
    assign ctrl     = rx_word[7:0];
    assign ch_ok    = ({1'b0, ctrl[5:0]} < 7'(NCH));
    assign ch_sel   = ctrl[CH_IW-1:0];

    function automatic logic [SH_W-1:0] align_top(input logic [SH_W-1:0] v, input int w);
        return v << (SH_W - w);
    endfunction

`ifdef SPI_BURST_EN
    localparam logic [CH_IW-1:0] LAST_CH = CH_IW'(NCH - 1);
    logic [CH_IW-1:0] ch_d;
    logic [CFG_W-1:0] reload_d;

    // A single-channel burst must read back the word it just committed.
    always_comb begin
        ch_d     = (ch_q == LAST_CH) ? '0 : ch_q + CH_IW'(1);
        reload_d = (wr_q && (ch_d == ch_q)) ? rx_word[CFG_W-1:0] : cfg_q[ch_d];
    end
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            sck_q      <= '0;
            ncs_q      <= '0;   // low until ncs is actually observed high
            mosi_q     <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            wr_q       <= 1'b0;
            rx_q       <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            cfg_q      <= CFG_RST;
            upd_q      <= '0;
            mem_addr_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sck_q  <= {sck_q[1:0], bus.sck_spi};
            ncs_q  <= {ncs_q[1:0], bus.ncs_spi};
            mosi_q <= {mosi_q[0], bus.mosi_spi};
            upd_q  <= '0;

            if (sck_rise) begin
                rx_q <= rx_word[RX_W-1:0];
            end

            if ((state_q != S_IDLE) && ncs_q[1]) begin
                state_q <= S_IDLE;
                miso_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                if (sck_fall && (state_q inside {S_CTRL, S_CFG, S_STAT, S_MEM})) begin
                    miso_q <= tx_q[SH_W-1];
                    tx_q   <= tx_q << 1;
                end

                case (state_q)
                    S_IDLE: begin
                        if (ncs_fall) begin
                            state_q    <= S_CTRL;
                            cnt_q      <= '0;
                            // DEV_ID MSB goes straight to MISO; the rest waits in tx_q.
                            miso_q     <= DEV_ID[7];
                            tx_q       <= align_top(SH_W'(DEV_ID), 7);
                            err_q      <= 1'b0;
                            mem_addr_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    S_CTRL: begin
                        if (sck_rise) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == CTRL_LAST) begin
                                cnt_q <= '0;
                                wr_q  <= ctrl[7];
                                if (ctrl[6]) begin
                                    state_q    <= S_STAT;
                                    tx_q       <= align_top(SH_W'(status_in), STATUS_W);
                                    mem_addr_q <= '0;
                                end else if (ch_ok) begin
                                    state_q <= S_CFG;
                                    ch_q    <= ch_sel;
                                    tx_q    <= align_top(SH_W'(cfg_q[ch_sel]), CFG_W);
                                end else begin
                                    state_q <= S_DONE;
                                    err_q   <= 1'b1;
                                    miso_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    S_CFG: begin
                        if (sck_rise) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == CFG_LAST) begin
                                cnt_q <= '0;
                                if (wr_q) begin
                                    cfg_q[ch_q] <= rx_word[CFG_W-1:0];
                                    upd_q[ch_q] <= 1'b1;
                                end
`ifdef SPI_BURST_EN
                                ch_q <= ch_d;
                                tx_q <= align_top(SH_W'(reload_d), CFG_W);
`else
                                state_q <= S_DONE;
                                miso_q  <= 1'b0;
`endif
                            end
                        end
                    end
                    S_STAT: begin
                        if (sck_rise) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == STAT_LAST) begin
                                cnt_q      <= '0;
                                state_q    <= S_MEM;
                                tx_q       <= align_top(SH_W'(bus.mem_data), MEM_W);
                                mem_addr_q <= mem_addr_q + MEM_AW'(1);
                            end
                        end
                    end
                    S_MEM: begin
                        if (sck_rise) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == MEM_LAST) begin
                                cnt_q      <= '0;
                                tx_q       <= align_top(SH_W'(bus.mem_data), MEM_W);
                                mem_addr_q <= mem_addr_q + MEM_AW'(1);
                            end
                        end
                    end
                    S_DONE: begin
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign cfg_out      = cfg_q;
    assign cfg_update   = upd_q;
    assign spi_err      = err_q;
    assign spi_busy     = busy_q;
    assign bus.miso_spi = miso_q;
    assign bus.mem_addr = mem_addr_q;
endmodule
`default_nettype wire
